result_conditioning: RTL and testbench
======================================

RESULT_CONDITIONING -- requirements
Module: result_conditioning

Interface
REQ-001 SHALL have parameter PAR, default 32, which is the operand/result word width.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 3, which is the opCode width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst_n. Reset is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- inValid  in  1  raw result offered by the datapath
- inReady  out  1  block accepts a raw result
- opCode  in  OPCODE_WIDTH  operation code of the offered result
- rawHi  in  PAR  product magnitude high word (mul); remainder magnitude (div)
- rawLo  in  PAR  product magnitude low word (mul); quotient magnitude (div)
- negResult  in  1  product or quotient must be negated
- negRem  in  1  remainder must be negated
- divByZero  in  1  divisor was zero
- dividendIn  in  PAR  original dividend, as written to the register file
- resultOut  out  PAR  conditioned architectural result
- divZeroOut  out  1  result came from a divide-by-zero
- outValid  out  1  resultOut valid
- outReady  in  1  consumer accepts resultOut

Function
REQ-005 Opcode decode SHALL be:
- 000 MUL: low word of the product.
- 001 MULH, 010 MULHSU, 011 MULHU: high word of the product.
- 100 DIV, 101 DIVU: quotient.
- 110 REM, 111 REMU: remainder.
REQ-006 Multiplication: if negResult=1, the full 2*PAR-bit value {rawHi,rawLo} SHALL be two's-complement negated before word selection. Borrow SHALL propagate from low word into high word.
REQ-007 DIV/DIVU: result SHALL be rawLo, negated when negResult=1.
REQ-008 REM/REMU: result SHALL be rawHi, negated when negRem=1.
REQ-009 divByZero=1 overrides REQ-007/REQ-008:
- quotient SHALL be all ones.
- remainder SHALL be dividendIn unchanged.
- negResult/negRem SHALL be ignored.
- divZeroOut SHALL be 1.
REQ-010 Signed overflow (most-negative value / -1) SHALL need no special path: magnitude 2^(PAR-1) with negResult=0 SHALL yield 0x8000_0000, and remainder SHALL be 0.
REQ-011 A transfer SHALL occur on inValid&&inReady at a rising clk edge. The conditioned result and divZeroOut SHALL be registered on that edge, and outValid SHALL be 1 in the next cycle (latency 1).
REQ-012 outValid, resultOut and divZeroOut SHALL hold stable while outValid=1 and outReady=0.
REQ-013 The output register SHALL empty on outValid&&outReady unless a new transfer occurs in the same edge. A simultaneous drain and fill SHALL load the new result with outValid held at 1.
REQ-014 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-015 Inputs other than inValid SHALL be don't-care when inValid=0.

Reset
REQ-016 While rst_n=0, the following SHALL be 0 asynchronously: outValid, resultOut, divZeroOut, and any skid-buffer contents and valid flag.
REQ-017 Reset asserted mid-operation SHALL discard all held results. The first transfer after release SHALL be accepted normally.
REQ-018 inReady SHALL be 1 in the first cycle after reset release.

Configuration
REQ-019 Macro RESULT_SKID_BUFFER_EN SHALL select the output buffering.
- Defined:
  - a one-entry skid buffer SHALL sit behind the output register.
  - inReady SHALL be a registered signal, equal to the skid buffer being empty.
  - full throughput SHALL be sustained.
  - a result arriving while the output register is stalled SHALL go to the skid buffer and move to the output register when it drains.
- Undefined:
  - no skid buffer.
  - inReady SHALL equal !outValid || outReady combinationally.

Verification
REQ-020 opCode=000, {rawHi,rawLo}=0x0000_0000_0000_0006, negResult=1 -> resultOut=0xFFFF_FFFA, divZeroOut=0, one cycle after accept.
REQ-021 opCode=001, {rawHi,rawLo}=0x0000_0001_0000_0000, negResult=1 -> resultOut=0xFFFF_FFFF (borrow propagated); same input with opCode=000 -> 0x0000_0000.
REQ-022 opCode=100, divByZero=1, dividendIn=0x0000_0007 -> resultOut=0xFFFF_FFFF, divZeroOut=1; opCode=110, same inputs -> resultOut=0x0000_0007.
REQ-023 opCode=110, rawHi=0x0000_0001, negRem=1 -> 0xFFFF_FFFF; opCode=100, rawLo=0x8000_0000, negResult=0 -> 0x8000_0000.
REQ-024 Back-to-back inputs A, B, C with outReady=0 for 3 cycles, then 1 -> outputs A, B, C in order, each held stable while stalled. Without macro: inReady=0 while stalled. With macro: B is accepted into the skid buffer, then inReady=0.
REQ-025 rst_n pulled low while outValid=1 and the skid buffer is full -> outValid=0 and resultOut=0 immediately; after release inReady=1 and the next result appears after 1 cycle.

Source files
------------

// File: rtl/result_conditioning.sv
// Conditions raw mul/div datapath magnitudes into architectural results behind a
// valid/ready output register; RESULT_SKID_BUFFER_EN adds a one-entry skid buffer.
module result_conditioning #(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PAR-1:0]          rawHi,
  input  logic [PAR-1:0]          rawLo,
  input  logic                    negResult,
  input  logic                    negRem,
  input  logic                    divByZero,
  input  logic [PAR-1:0]          dividendIn,
  output logic [PAR-1:0]          resultOut,
  output logic                    divZeroOut,
  output logic                    outValid,
  input  logic                    outReady
);

  // Handshake: a word moves on an interface at a rising edge where valid && ready;
  // valid never depends on ready, and an offered word is held until it moves.

  logic [2:0]       op;
  logic [2*PAR-1:0] prodMag;
  logic [2*PAR-1:0] prodSigned;
  logic [PAR-1:0]   quotient;
  logic [PAR-1:0]   remainder;
  logic [PAR-1:0]   condResult;
  logic             condDz;
  logic             accept;

  assign op = opCode[2:0];

  // Negate the full double word so the borrow ripples from low into high.
  assign prodMag    = {rawHi, rawLo};
  assign prodSigned = negResult ? -prodMag : prodMag;

  assign quotient  = divByZero ? {PAR{1'b1}} : (negResult ? -rawLo : rawLo);
  assign remainder = divByZero ? dividendIn  : (negRem    ? -rawHi : rawHi);

  always_comb begin
    condResult = remainder;
    case (op)
      3'b000:                 condResult = prodSigned[PAR-1:0];
      3'b001, 3'b010, 3'b011: condResult = prodSigned[2*PAR-1:PAR];
      3'b100, 3'b101:         condResult = quotient;
      default:                condResult = remainder;
    endcase
  end

  assign condDz = op[2] & divByZero;
  assign accept = inValid && inReady;

`ifdef RESULT_SKID_BUFFER_EN
  logic [PAR-1:0] skidResult;
  logic           skidDz;
  logic           skidValid;
  logic           outFree;
  logic           skidValidNext;

  assign outFree       = !outValid || outReady;
  // A stalled output keeps whatever sits in the skid slot, plus any new accept.
  assign skidValidNext = !outFree && (skidValid || accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid   <= 1'b0;
      resultOut  <= '0;
      divZeroOut <= 1'b0;
      skidValid  <= 1'b0;
      skidResult <= '0;
      skidDz     <= 1'b0;
      inReady    <= 1'b1;
    end else begin
      if (outFree) begin
        if (skidValid) begin
          outValid   <= 1'b1;
          resultOut  <= skidResult;
          divZeroOut <= skidDz;
        end else if (accept) begin
          outValid   <= 1'b1;
          resultOut  <= condResult;
          divZeroOut <= condDz;
        end else begin
          outValid   <= 1'b0;
        end
      end else if (accept) begin
        skidResult <= condResult;
        skidDz     <= condDz;
      end
      skidValid <= skidValidNext;
      inReady   <= !skidValidNext;
    end
  end
`else
  assign inReady = !outValid || outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid   <= 1'b0;
      resultOut  <= '0;
      divZeroOut <= 1'b0;
    end else if (accept) begin
      outValid   <= 1'b1;
      resultOut  <= condResult;
      divZeroOut <= condDz;
    end else if (outReady) begin
      outValid   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_result_conditioning.sv
// Bench for result_conditioning: directed vector table, stall/reset sequences and
// randomized traffic scored against a spec-level reference model.
module tb_result_conditioning;
  localparam int PAR = 32;

  logic           clk;
  logic           rst_n;
  logic           inValid;
  logic           inReady;
  logic [2:0]     opCode;
  logic [PAR-1:0] rawHi;
  logic [PAR-1:0] rawLo;
  logic           negResult;
  logic           negRem;
  logic           divByZero;
  logic [PAR-1:0] dividendIn;
  logic [PAR-1:0] resultOut;
  logic           divZeroOut;
  logic           outValid;
  logic           outReady;

  result_conditioning #(.PAR(PAR), .OPCODE_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .opCode(opCode), .rawHi(rawHi), .rawLo(rawLo), .negResult(negResult),
    .negRem(negRem), .divByZero(divByZero), .dividendIn(dividendIn),
    .resultOut(resultOut), .divZeroOut(divZeroOut), .outValid(outValid),
    .outReady(outReady)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {divZero, result} straight from the opcode rules.
  function automatic logic [PAR:0] model(input logic [2:0] op, input logic [PAR-1:0] hi,
                                         input logic [PAR-1:0] lo, input logic nR,
                                         input logic nRem, input logic dbz,
                                         input logic [PAR-1:0] dvd);
    logic [2*PAR-1:0] product;
    logic [PAR-1:0]   r;
    logic             dz;
    product = {hi, lo};
    if (nR) product = (2*PAR)'(0) - product;
    dz = 1'b0;
    if (op == 3'd0)      r = product[PAR-1:0];
    else if (op <= 3'd3) r = product[2*PAR-1:PAR];
    else if (dbz) begin
      dz = 1'b1;
      r  = (op <= 3'd5) ? 32'hFFFF_FFFF : dvd;
    end
    else if (op <= 3'd5) r = nR   ? (32'd0 - lo) : lo;
    else                 r = nRem ? (32'd0 - hi) : hi;
    return {dz, r};
  endfunction

  // scoreboard: expected queue filled on accept, drained on output transfer
  logic [PAR:0]   expQ[$];
  logic [PAR:0]   expHead;
  logic           prevStall = 1'b0;
  logic [PAR-1:0] prevRes;
  logic           prevDz;

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        check("holdValid", 64'(outValid), 64'd1);
        check("holdResult", 64'(resultOut), 64'(prevRes));
        check("holdDz", 64'(divZeroOut), 64'(prevDz));
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extraOutput: got %h with nothing expected", resultOut);
        end else begin
          expHead = expQ.pop_front();
          check("orderResult", 64'(resultOut), 64'(expHead[PAR-1:0]));
          check("orderDz", 64'(divZeroOut), 64'(expHead[PAR]));
        end
      end
      prevStall = outValid && !outReady;
      prevRes   = resultOut;
      prevDz    = divZeroOut;
      if (inValid && inReady)
        expQ.push_back(model(opCode, rawHi, rawLo, negResult, negRem, divByZero, dividendIn));
    end
  end

  // driver tasks
  task automatic driveIn(input logic [2:0] op, input logic [PAR-1:0] hi, input logic [PAR-1:0] lo,
                         input logic nR, input logic nRem, input logic dbz,
                         input logic [PAR-1:0] dvd);
    opCode = op; rawHi = hi; rawLo = lo; negResult = nR; negRem = nRem;
    divByZero = dbz; dividendIn = dvd;
  endtask

  task automatic sendItem(input logic [2:0] op, input logic [PAR-1:0] hi, input logic [PAR-1:0] lo,
                          input logic nR, input logic nRem, input logic dbz,
                          input logic [PAR-1:0] dvd);
    logic accepted;
    driveIn(op, hi, lo, nR, nRem, dbz, dvd);
    inValid  = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 64 && !accepted; c++) begin
      @(negedge clk);
      accepted = inReady;
      @(posedge clk);
      #1;
    end
    total++;
    if (!accepted) begin
      bad++;
      $display("FAIL acceptTimeout: got inReady=0 for 64 cycles want accept");
    end
    inValid = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int c = 0; c < 200 && expQ.size() != 0; c++) @(posedge clk);
    #1;
    check("drainEmpty", 64'(expQ.size()), 64'd0);
  endtask

  typedef struct packed {
    logic [2:0]     op;
    logic [PAR-1:0] hi;
    logic [PAR-1:0] lo;
    logic           nR;
    logic           nRem;
    logic           dbz;
    logic [PAR-1:0] dvd;
    logic [PAR-1:0] expRes;
    logic           expDz;
  } vecT;

  vecT        vecs[11];
  logic [PAR:0] e;
  bit         randDone;

  initial begin
    vecs[0]  = '{3'd0, 32'h0,        32'h6,        1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFFA, 1'b0};
    vecs[1]  = '{3'd1, 32'h1,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{3'd0, 32'h1,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
    vecs[3]  = '{3'd4, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h7,        32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{3'd6, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h7,        32'h0000_0007, 1'b1};
    vecs[5]  = '{3'd6, 32'h1,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd4, 32'h0,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0,       32'h8000_0000, 1'b0};
    vecs[7]  = '{3'd7, 32'h0,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0,       32'h0000_0000, 1'b0};
    vecs[8]  = '{3'd3, 32'h1234_5678, 32'h9,       1'b0, 1'b0, 1'b0, 32'h0,        32'h1234_5678, 1'b0};
    vecs[9]  = '{3'd5, 32'h5,        32'h3,        1'b1, 1'b1, 1'b1, 32'h55,       32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{3'd7, 32'h5,        32'h3,        1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1};

    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
    driveIn(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    #12;
    check("rstOutValid", 64'(outValid), 64'd0);
    check("rstResult", 64'(resultOut), 64'd0);
    check("rstDz", 64'(divZeroOut), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rstInReady", 64'(inReady), 64'd1);
    @(posedge clk); #1;

    // directed table: result visible exactly one cycle after accept
    outReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      driveIn(vecs[i].op, vecs[i].hi, vecs[i].lo, vecs[i].nR, vecs[i].nRem, vecs[i].dbz, vecs[i].dvd);
      inValid = 1'b1;
      @(negedge clk);
      check($sformatf("vecReady%0d", i), 64'(inReady), 64'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      check($sformatf("vecValid%0d", i), 64'(outValid), 64'd1);
      check($sformatf("vecResult%0d", i), 64'(resultOut), 64'(vecs[i].expRes));
      check($sformatf("vecDz%0d", i), 64'(divZeroOut), 64'(vecs[i].expDz));
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    // A, B, C back to back with a three-cycle output stall
    outReady = 1'b0;
    fork
      begin
        sendItem(3'd0, 32'h0, 32'hA, 1'b0, 1'b0, 1'b0, 32'h0);
        sendItem(3'd4, 32'h0, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0);
        sendItem(3'd6, 32'hC, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC0C0);
      end
      begin
        @(negedge clk);
        check("stallReadyA", 64'(inReady), 64'd1);
        @(negedge clk);
`ifdef RESULT_SKID_BUFFER_EN
        check("stallReadyB", 64'(inReady), 64'd1);
`else
        check("stallReadyB", 64'(inReady), 64'd0);
`endif
        @(negedge clk);
        check("stallReadyC", 64'(inReady), 64'd0);
        @(posedge clk); #1;
        outReady = 1'b1;
      end
    join
    drain();

    // reset while holding results
    outReady = 1'b0;
    sendItem(3'd0, 32'h0, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef RESULT_SKID_BUFFER_EN
    sendItem(3'd0, 32'h0, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0);
`endif
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midRstValid", 64'(outValid), 64'd0);
    check("midRstResult", 64'(resultOut), 64'd0);
    check("midRstDz", 64'(divZeroOut), 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("postRstReady", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    outReady = 1'b1;
    sendItem(3'd1, 32'h0, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0);
    check("postRstValid", 64'(outValid), 64'd1);
    check("postRstResult", 64'(resultOut), 64'hFFFF_FFFF);
    drain();

    // randomized traffic with random back-pressure
    randDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          e[0] = 1'b0;
          sendItem(3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom(),
                   ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), $urandom());
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk); #1;
          outReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL globalTimeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
